// File: rtl/temporal_pkg.sv
// Shared types and width helpers for the temporal LE comparator array.
package temporal_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    FIRE    = 2'd1,
    BLOCKED = 2'd2,
    DONE    = 2'd3
  } chan_state_t;

  localparam int PULSE_MODE_LEVEL = 0;
  localparam int PULSE_MODE_PULSE = 1;

  function automatic int slot_w(input int gcw);
    return $clog2(gcw);
  endfunction

  function automatic int cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/temporal_le_array_if.sv
// Event and timebase bundle for temporal_le_array.
interface temporal_le_array_if
  import temporal_pkg::*;
#(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16
) ();

  localparam int SW = slot_w(GAMMA_CYCLE_WIDTH);

  logic            gamma_sync;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] q;
  logic [SW-1:0]   gamma_slot;
  logic            gamma_last;

  modport master (
    output gamma_sync, a, b,
    input  q, gamma_slot, gamma_last
  );

  modport slave (
    input  gamma_sync, a, b,
    output q, gamma_slot, gamma_last
  );

endinterface

// File: rtl/temporal_le_chan.sv
// One race-logic LE channel: edge detect, FSM, pulse counter.
// TEMPORAL_LE_STRICT_LT_EN turns ties into blocks (strict less-than).
module temporal_le_chan
  import temporal_pkg::*;
#(
  parameter int PULSE_WIDTH = 8,
  parameter int PULSE_MODE  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_a,
  input  logic i_b,
  output logic o_q
);

  localparam int CW = cnt_w(PULSE_WIDTH);
  localparam logic [CW-1:0] PW_M1 = CW'(PULSE_WIDTH - 1);

  chan_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_q;
  logic          r_a_prev;
  logic          r_b_prev;
  logic          r_live;
  logic          w_ev_a;
  logic          w_ev_b;
  logic          w_win;

  // r_live masks the first edge after reset so a level held
  // through reset is not mistaken for a fresh event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_prev <= 1'b0;
      r_b_prev <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_a_prev <= i_a;
      r_b_prev <= i_b;
      r_live   <= 1'b1;
    end
  end

  assign w_ev_a = r_live & i_a & ~r_a_prev;
  assign w_ev_b = r_live & i_b & ~r_b_prev;

`ifdef TEMPORAL_LE_STRICT_LT_EN
  assign w_win = w_ev_a & ~w_ev_b;
`else
  assign w_win = w_ev_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARMED;
      r_cnt   <= '0;
      r_q     <= 1'b0;
    end else if (i_clear) begin
      r_state <= ARMED;
      r_cnt   <= '0;
      r_q     <= 1'b0;
    end else begin
      unique case (r_state)
        ARMED: begin
          if (w_win) begin
            r_state <= FIRE;
            r_q     <= 1'b1;
            r_cnt   <= PW_M1;
          end else if (w_ev_b) begin
            r_state <= BLOCKED;
          end
        end
        FIRE: begin
          if (PULSE_MODE == PULSE_MODE_LEVEL) begin
            r_state <= DONE;
          end else if (r_cnt == '0) begin
            r_q     <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/temporal_le_array.sv
// N-channel clocked race-logic LE array with gamma timebase.
// TEMPORAL_LE_STRICT_LT_EN selects strict less-than tie handling.
module temporal_le_array
  import temporal_pkg::*;
#(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int PULSE_MODE        = 0
) (
  input logic                clk,
  input logic                rst,
  temporal_le_array_if.slave bus
);

  localparam int SW = slot_w(GAMMA_CYCLE_WIDTH);
  localparam logic [SW-1:0] LAST = SW'(GAMMA_CYCLE_WIDTH - 1);

  logic [SW-1:0]   r_slot;
  logic            w_last;
  logic            w_clear;
  logic [N_CH-1:0] w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (bus.gamma_sync || w_last) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign w_last  = (r_slot == LAST);
  assign w_clear = w_last | bus.gamma_sync;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    temporal_le_chan #(
      .PULSE_WIDTH (PULSE_WIDTH),
      .PULSE_MODE  (PULSE_MODE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_a     (bus.a[i]),
      .i_b     (bus.b[i]),
      .o_q     (w_q[i])
    );
  end

  // Reset slot masks q; state itself clears on the edge ending it.
  assign bus.q          = w_q & ~{N_CH{w_last}};
  assign bus.gamma_slot = r_slot;
  assign bus.gamma_last = w_last;

endmodule
